// File: rtl/shifter_pkg.sv
// Shared types and elaboration-time sanity checks for the right barrel
// shifter pipeline.
`ifndef SHIFTER_PKG_SV
`define SHIFTER_PKG_SV

package shifter_pkg;

  typedef enum logic {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ARITH   = 1'b1
  } shift_mode_e;

  // Largest shamt width whose maximum shift (2**depth-1) still fits in width-1.
  function automatic int unsigned max_depth(input int unsigned width);
    return $clog2(width + 1) - 1;
  endfunction

  function automatic bit depth_fits(input int unsigned width, input int unsigned depth);
    return (width >= 2) && (depth >= 1) && (depth <= max_depth(width));
  endfunction

endpackage

`define SHIFTER_STATIC_ASSERT(cond, msg) \
  if (!(cond)) begin : g_static_assert \
    $error(msg); \
  end

`endif

// File: rtl/barrel_shifter_right_row.sv
// One combinational row of the right barrel shifter: optional fixed shift by
// SHIFT with fill, accumulating the shifted-out bits into sticky.
module barrel_shifter_right_row #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             sticky_i,
  input  logic             ctrl_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sticky_o
);

  always_comb begin
    data_o   = data_i;
    sticky_o = sticky_i;
    if (ctrl_i) begin
      data_o   = {{SHIFT{fill_i}}, data_i[WIDTH-1:SHIFT]};
      sticky_o = sticky_i | (|data_i[SHIFT-1:0]);
    end
  end

endmodule

// File: rtl/barrel_shifter_right_pipe.sv
// Pipelined right barrel shifter: one registered row per shift-amount bit,
// logical/arithmetic fill, sticky OR of shifted-out bits, valid/ready flow.
module barrel_shifter_right_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] in_shamt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  `SHIFTER_STATIC_ASSERT(depth_fits(WIDTH, DEPTH), "barrel_shifter_right_pipe: 2**DEPTH-1 must not exceed WIDTH-1")

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             sticky;
    logic [DEPTH-1:0] shamt;
    shift_mode_e      mode;
  } stage_t;

  stage_t           stage_q    [DEPTH];
  stage_t           stage_d    [DEPTH];
  stage_t           row_in     [DEPTH];
  logic [WIDTH-1:0] row_data   [DEPTH];
  logic             row_sticky [DEPTH];
  logic             en         [DEPTH+1];

  assign en[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign row_in[k] = '{valid: in_valid, data: in_data, sticky: 1'b0,
                           shamt: in_shamt, mode: shift_mode_e'(in_arith)};
    end else begin : g_src
      assign row_in[k] = stage_q[k-1];
    end

    // A stage loads whenever it is empty or its successor is loading, so
    // bubbles collapse and backpressure ripples combinationally to in_ready.
    assign en[k] = ~stage_q[k].valid | en[k+1];

    barrel_shifter_right_row #(
      .WIDTH(WIDTH),
      .SHIFT(2 ** k)
    ) u_row (
      .data_i  (row_in[k].data),
      .sticky_i(row_in[k].sticky),
      .ctrl_i  (row_in[k].shamt[k]),
      .fill_i  ((row_in[k].mode == SHIFT_ARITH) & row_in[k].data[WIDTH-1]),
      .data_o  (row_data[k]),
      .sticky_o(row_sticky[k])
    );

    assign stage_d[k] = '{valid: row_in[k].valid, data: row_data[k], sticky: row_sticky[k],
                          shamt: row_in[k].shamt, mode: row_in[k].mode};

    // Payload only moves with a valid beat, so idle inputs never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[k] <= '0;
      end else if (en[k]) begin
        if (row_in[k].valid) begin
          stage_q[k] <= stage_d[k];
        end else begin
          stage_q[k].valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready   = en[0];
  assign out_valid  = stage_q[DEPTH-1].valid;
  assign out_data   = stage_q[DEPTH-1].data;
  assign out_sticky = stage_q[DEPTH-1].sticky;

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Directed and streaming checks for barrel_shifter_right_pipe at WIDTH=8, DEPTH=3.
module tb_barrel_shifter_right_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] in_shamt;
  logic             in_arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  int tests = 0;
  int fails = 0;

  barrel_shifter_right_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  // Directed single-beat vectors: data, shamt, arith -> result, sticky
  localparam logic [7:0] DV_D [6] = '{8'hB4, 8'hB4, 8'h80, 8'h80, 8'h5A, 8'h5A};
  localparam logic [2:0] DV_S [6] = '{3'd3, 3'd3, 3'd7, 3'd7, 3'd0, 3'd0};
  localparam logic       DV_A [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] DV_R [6] = '{8'h16, 8'hF6, 8'hFF, 8'h01, 8'h5A, 8'h5A};
  localparam logic       DV_K [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // Backpressure beats (the fourth must never be accepted)
  localparam logic [7:0] BP_D [4] = '{8'h11, 8'hF0, 8'h0F, 8'h77};
  localparam logic [2:0] BP_S [4] = '{3'd1, 3'd4, 3'd2, 3'd3};
  localparam logic       BP_A [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] BP_R [3] = '{8'h08, 8'hFF, 8'h03};
  localparam logic       BP_K [3] = '{1'b1, 1'b0, 1'b1};

  // Full-pipeline simultaneous drain/accept beats
  localparam logic [7:0] FA_D [4] = '{8'h01, 8'hC0, 8'h90, 8'h3C};
  localparam logic [2:0] FA_S [4] = '{3'd0, 3'd6, 3'd2, 3'd3};
  localparam logic       FA_A [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [7:0] FA_R [4] = '{8'h01, 8'h03, 8'hE4, 8'h07};
  localparam logic       FA_K [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Reference: place operand in a 24-bit window with 8 fill bits above and
  // 8 zero bits below, shift, then read result and shifted-out bits.
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic a);
    logic [23:0] w;
    w = {((a && d[7]) ? 8'hFF : 8'h00), d, 8'h00} >> s;
    return {|w[7:0], w[15:8]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0;
    in_data  = 'x;
    in_shamt = 'x;
    in_arith = 1'bx;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic [2:0] s, input logic a);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_arith = a;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    #12;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sticky !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b data=%h sticky=%b, expected 0/00/0",
               out_valid, out_data, out_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_directed;
    for (int i = 0; i < 6; i++) begin
      tick();
      out_ready = 1'b1;
      drive_beat(DV_D[i], DV_S[i], DV_A[i]);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL directed%0d_in_ready: got %b, expected 1", i, in_ready);
      end
      tick();
      idle_inputs();
      repeat (2) @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL directed%0d_early: out_valid=%b two cycles after accept, expected 0",
                 i, out_valid);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== DV_R[i] || out_sticky !== DV_K[i]) begin
        fails++;
        $display("FAIL directed%0d_result: got valid=%b data=%h sticky=%b, expected 1/%h/%b",
                 i, out_valid, out_data, out_sticky, DV_R[i], DV_K[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int acc;
    acc = 0;
    tick();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc > 0) tick();
      drive_beat(BP_D[acc], BP_S[acc], BP_A[acc]);
      @(negedge clk);
      if (cyc >= 3) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== BP_R[0] || out_sticky !== BP_K[0]) begin
          fails++;
          $display("FAIL bp_hold%0d: got valid=%b data=%h sticky=%b, expected 1/%h/%b",
                   cyc, out_valid, out_data, out_sticky, BP_R[0], BP_K[0]);
        end
      end
      if (in_ready && acc < 3) acc++;
      else if (in_ready) begin
        tests++;
        fails++;
        $display("FAIL bp_overfill: in_ready=1 with 3 beats held, expected 0");
      end
    end
    tests++;
    if (acc != 3 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept_count: got %0d beats in_ready=%b, expected 3 beats in_ready=0",
               acc, in_ready);
    end
    tick();
    idle_inputs();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      else begin
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL bp_release_ready: got %b, expected 1", in_ready);
        end
      end
      tests++;
      if (out_valid !== 1'b1 || out_data !== BP_R[j] || out_sticky !== BP_K[j]) begin
        fails++;
        $display("FAIL bp_drain%0d: got valid=%b data=%h sticky=%b, expected 1/%h/%b",
                 j, out_valid, out_data, out_sticky, BP_R[j], BP_K[j]);
      end
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: out_valid=%b after draining, expected 0", out_valid);
    end
  endtask

  task automatic test_full_accept;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      drive_beat(FA_D[i], FA_S[i], FA_A[i]);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL full_fill%0d: in_ready=%b, expected 1", i, in_ready);
      end
    end
    tick();
    drive_beat(FA_D[3], FA_S[3], FA_A[3]);
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== FA_R[0]) begin
      fails++;
      $display("FAIL full_passthru: got in_ready=%b valid=%b data=%h, expected 1/1/%h",
               in_ready, out_valid, out_data, FA_R[0]);
    end
    tick();
    idle_inputs();
    out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== FA_R[1]) begin
      fails++;
      $display("FAIL full_occupancy: got in_ready=%b valid=%b data=%h, expected 0/1/%h",
               in_ready, out_valid, out_data, FA_R[1]);
    end
    tick();
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== FA_R[j] || out_sticky !== FA_K[j]) begin
        fails++;
        $display("FAIL full_drain%0d: got valid=%b data=%h sticky=%b, expected 1/%h/%b",
                 j, out_valid, out_data, out_sticky, FA_R[j], FA_K[j]);
      end
    end
  endtask

  task automatic test_stream;
    logic [8:0] q[$];
    logic [8:0] exp;
    int sent;
    int got;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20 && $urandom_range(0, 1) == 1)
        drive_beat(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
      else
        idle_inputs();
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: got data=%h sticky=%b, expected no beat",
                   out_data, out_sticky);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp[7:0] || out_sticky !== exp[8]) begin
            fails++;
            $display("FAIL stream_beat%0d: got data=%h sticky=%b, expected %h/%b",
                     got, out_data, out_sticky, exp[7:0], exp[8]);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_shift(in_data, in_shamt, in_arith));
        sent++;
      end
    end
    tests++;
    if (got != 20 || sent != 20 || q.size() != 0) begin
      fails++;
      $display("FAIL stream_count: got %0d out, %0d in, %0d pending, expected 20/20/0",
               got, sent, q.size());
    end
  endtask

  task automatic test_async_reset;
    logic stale;
    tick();
    idle_inputs();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    drive_beat(8'hAA, 3'd1, 1'b0);
    tick();
    drive_beat(8'h55, 3'd2, 1'b1);
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL areset_inflight: out_valid=%b before reset, expected 1", out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sticky !== 1'b0) begin
      fails++;
      $display("FAIL areset_immediate: got valid=%b data=%h sticky=%b, expected 0/00/0",
               out_valid, out_data, out_sticky);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stale = stale | out_valid;
    end
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL areset_stale: out_valid seen=%b after reset, expected 0", stale);
    end
    tick();
    drive_beat(8'h01, 3'd1, 1'b0);
    tick();
    idle_inputs();
    repeat (2) @(negedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || out_sticky !== 1'b1) begin
      fails++;
      $display("FAIL areset_newbeat: got valid=%b data=%h sticky=%b, expected 1/00/1",
               out_valid, out_data, out_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_full_accept();
    test_stream();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
